// File: rtl/cache_2way_param.sv
// Two-way set-associative, write-back / write-allocate cache with a three-state miss FSM.
// Optional hit/miss counters are built only when CACHE_STATS_EN is defined.
module cache_2way_param #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int IDX_W  = 2,
    parameter int OFF_W  = 2
) (
    input  logic                                clock,
    input  logic                                reset,
    input  logic                                read,
    input  logic                                write,
    input  logic [ADDR_W-1:0]                   address,
    input  logic [DATA_W-1:0]                   writedata,
    output logic [DATA_W-1:0]                   readdata,
    output logic                                busywait,
    output logic                                mem_read,
    output logic                                mem_write,
    output logic [ADDR_W-OFF_W-1:0]             mem_address,
    output logic [DATA_W*(2**OFF_W)-1:0]        mem_writedata,
    input  logic [DATA_W*(2**OFF_W)-1:0]        mem_readdata,
    input  logic                                mem_busywait
`ifdef CACHE_STATS_EN
    ,
    output logic [15:0]                         hit_count,
    output logic [15:0]                         miss_count
`endif
);

    localparam int TAG_W = ADDR_W - IDX_W - OFF_W;
    localparam int SETS  = 2 ** IDX_W;
    localparam int WORDS = 2 ** OFF_W;
    localparam int BLK_W = DATA_W * WORDS;

    typedef enum logic [1:0] {StIdle, StWriteback, StFetch} state_e;

    state_e             r_state;
    logic [SETS-1:0]    r_valid [2];
    logic [SETS-1:0]    r_dirty [2];
    logic [SETS-1:0]    r_lru;
    logic               r_victim;
    logic [TAG_W-1:0]   r_tag   [2][SETS];
    logic [BLK_W-1:0]   r_data  [2][SETS];

    logic [OFF_W-1:0]   w_off;
    logic [IDX_W-1:0]   w_idx;
    logic [TAG_W-1:0]   w_tag;
    logic               w_access;
    logic [1:0]         w_match;
    logic               w_hit;
    logic               w_hit_way;
    logic               w_victim;
    logic               w_fill;

    assign w_off    = address[OFF_W-1:0];
    assign w_idx    = address[OFF_W +: IDX_W];
    assign w_tag    = address[ADDR_W-1 -: TAG_W];
    // read and write together is deliberately treated as no access at all
    assign w_access = read ^ write;

    assign w_match[0] = r_valid[0][w_idx] && (r_tag[0][w_idx] == w_tag);
    assign w_match[1] = r_valid[1][w_idx] && (r_tag[1][w_idx] == w_tag);
    assign w_hit      = (r_state == StIdle) && w_access && (|w_match);
    assign w_hit_way  = !w_match[0];
    assign w_victim   = !r_valid[0][w_idx] ? 1'b0 :
                        !r_valid[1][w_idx] ? 1'b1 : r_lru[w_idx];
    assign w_fill     = (r_state == StFetch) && !mem_busywait && !reset;

    assign busywait  = w_access && !w_hit && !reset;
    assign readdata  = (w_hit && read) ?
                       r_data[w_hit_way][w_idx][w_off*DATA_W +: DATA_W] : '0;

    assign mem_read      = (r_state == StFetch);
    assign mem_write     = (r_state == StWriteback);
    assign mem_address   = (r_state == StWriteback) ? {r_tag[r_victim][w_idx], w_idx}
                                                    : {w_tag, w_idx};
    assign mem_writedata = r_data[r_victim][w_idx];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state  <= StIdle;
            r_valid  <= '{default: '0};
            r_dirty  <= '{default: '0};
            r_lru    <= '0;
            r_victim <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_hit) begin
                        r_lru[w_idx] <= ~w_hit_way;
                        if (write) r_dirty[w_hit_way][w_idx] <= 1'b1;
                    end else if (w_access) begin
                        r_victim <= w_victim;
                        r_state  <= (r_valid[w_victim][w_idx] && r_dirty[w_victim][w_idx]) ?
                                    StWriteback : StFetch;
                    end
                end
                StWriteback: begin
                    if (!mem_busywait) r_state <= StFetch;
                end
                StFetch: begin
                    if (!mem_busywait) begin
                        r_valid[r_victim][w_idx] <= 1'b1;
                        r_dirty[r_victim][w_idx] <= 1'b0;
                        r_state                  <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // Block and tag storage carries no reset; only the valid bits qualify it.
    always_ff @(posedge clock) begin
        if (w_hit && write) begin
            r_data[w_hit_way][w_idx][w_off*DATA_W +: DATA_W] <= writedata;
        end
        if (w_fill) begin
            r_data[r_victim][w_idx] <= mem_readdata;
            r_tag[r_victim][w_idx]  <= w_tag;
        end
    end

`ifdef CACHE_STATS_EN
    logic        r_refill;
    logic [15:0] r_hit_cnt;
    logic [15:0] r_miss_cnt;

    // The retried access right after a fill completes the original miss, not a new hit.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_refill   <= 1'b0;
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            r_refill <= w_fill;
            if (w_hit && !r_refill && (r_hit_cnt != 16'hFFFF)) begin
                r_hit_cnt <= r_hit_cnt + 16'd1;
            end
            if ((r_state == StIdle) && w_access && !w_hit && (r_miss_cnt != 16'hFFFF)) begin
                r_miss_cnt <= r_miss_cnt + 16'd1;
            end
        end
    end

    assign hit_count  = r_hit_cnt;
    assign miss_count = r_miss_cnt;
`endif

endmodule

// File: tb/tb_cache_2way_param.sv
// Scoreboard bench for cache_2way_param with a fixed-latency block memory model.
// Counter checks are included when CACHE_STATS_EN is defined.
module tb_cache_2way_param;

    localparam int MEM_LAT = 3;

    logic        clk;
    logic        rst;
    logic        read;
    logic        write;
    logic [7:0]  address;
    logic [7:0]  writedata;
    logic [7:0]  readdata;
    logic        busywait;
    logic        mem_read;
    logic        mem_write;
    logic [5:0]  mem_address;
    logic [31:0] mem_writedata;
    logic [31:0] mem_readdata;
    logic        mem_busywait;
`ifdef CACHE_STATS_EN
    logic [15:0] hit_count;
    logic [15:0] miss_count;
`endif

    cache_2way_param dut (
        .clock         (clk),
        .reset         (rst),
        .read          (read),
        .write         (write),
        .address       (address),
        .writedata     (writedata),
        .readdata      (readdata),
        .busywait      (busywait),
        .mem_read      (mem_read),
        .mem_write     (mem_write),
        .mem_address   (mem_address),
        .mem_writedata (mem_writedata),
        .mem_readdata  (mem_readdata),
        .mem_busywait  (mem_busywait)
`ifdef CACHE_STATS_EN
        ,
        .hit_count     (hit_count),
        .miss_count    (miss_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0]  rd_q  [$];
    logic [38:0] exp_ops [$];
    logic [38:0] obs_ops [$];

    // Memory model: busy from the cycle a request rises, done after MEM_LAT busy cycles.
    logic [31:0] mem [64];
    int          mem_cnt;

    assign mem_busywait = (mem_read || mem_write) && (mem_cnt < MEM_LAT);
    assign mem_readdata = mem[mem_address];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_cnt <= 0;
            for (int i = 0; i < 64; i++) mem[i] <= {4{i[7:0]}};
            mem[9] <= 32'hDDCCBBAA;
        end else if (mem_read || mem_write) begin
            if (mem_cnt < MEM_LAT) begin
                mem_cnt <= mem_cnt + 1;
            end else begin
                mem_cnt <= 0;
                if (mem_write) mem[mem_address] <= mem_writedata;
                obs_ops.push_back({mem_write, mem_address,
                                   mem_write ? mem_writedata : mem_readdata});
            end
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic exp_op(input logic wr, input logic [5:0] a, input logic [31:0] d);
        exp_ops.push_back({wr, a, d});
    endtask

    task automatic check_ops(input string tag);
        int n;
        check_eq({tag, "_nops"}, 64'(obs_ops.size()), 64'(exp_ops.size()));
        n = (obs_ops.size() < exp_ops.size()) ? obs_ops.size() : exp_ops.size();
        for (int i = 0; i < n; i++) check_eq({tag, "_op"}, 64'(obs_ops[i]), 64'(exp_ops[i]));
        obs_ops.delete();
        exp_ops.delete();
    endtask

    // Called just after a rising edge; returns just after the completing edge.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [7:0] a, input logic [7:0] wd,
                          input logic [7:0] exp_rd, input int exp_lat);
        int lat = 0;
        if (rd) rd_q.push_back(exp_rd);
        read = rd; write = wr; address = a; writedata = wd;
        @(negedge clk);
        while (busywait && lat < 200) begin
            lat++;
            @(negedge clk);
        end
        if (lat >= 200) check_eq({tag, "_timeout"}, 64'(busywait), 64'd0);
        if (rd) check_eq({tag, "_rdata"}, 64'(readdata), 64'(rd_q.pop_front()));
        check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
        check_ops(tag);
    endtask

    initial begin
        logic traffic;
        rst = 1'b1; read = 1'b0; write = 1'b0; address = '0; writedata = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_busy", 64'(busywait), 64'd0);
        check_eq("rst_mrd",  64'(mem_read), 64'd0);
        check_eq("rst_mwr",  64'(mem_write), 64'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        exp_op(1'b0, 6'h09, 32'hDDCCBBAA);
        access("rd24", 1, 0, 8'h24, 8'h00, 8'hAA, 5);
        access("wr25", 0, 1, 8'h25, 8'h5A, 8'h00, 0);
        access("rd25", 1, 0, 8'h25, 8'h00, 8'h5A, 0);
        exp_op(1'b0, 6'h11, 32'h11111111);
        access("rd44", 1, 0, 8'h44, 8'h00, 8'h11, 5);
        access("rd44b", 1, 0, 8'h44, 8'h00, 8'h11, 0);
        exp_op(1'b1, 6'h09, 32'hDDCC5AAA);
        exp_op(1'b0, 6'h31, 32'h31313131);
        access("rdC4", 1, 0, 8'hC4, 8'h00, 8'h31, 9);
`ifdef CACHE_STATS_EN
        check_eq("hit_cnt",  64'(hit_count), 64'd3);
        check_eq("miss_cnt", 64'(miss_count), 64'd3);
`endif

        // Written-back line comes back from memory into the clean LRU way.
        exp_op(1'b0, 6'h09, 32'hDDCC5AAA);
        access("rd25m", 1, 0, 8'h25, 8'h00, 8'h5A, 5);
        access("rdC4h", 1, 0, 8'hC4, 8'h00, 8'h31, 0);

        exp_op(1'b0, 6'h3F, 32'h3F3F3F3F);
        access("rdFF", 1, 0, 8'hFF, 8'h00, 8'h3F, 5);
        access("wrFC", 0, 1, 8'hFC, 8'h77, 8'h00, 0);
        access("rdFC", 1, 0, 8'hFC, 8'h00, 8'h77, 0);
        access("rdFFb", 1, 0, 8'hFF, 8'h00, 8'h3F, 0);

        // read and write together: no access
        read = 1'b1; write = 1'b1; address = 8'h24; writedata = 8'hEE;
        #1;
        check_eq("rw_busy", 64'(busywait), 64'd0);
        traffic = 1'b0;
        repeat (3) begin
            @(negedge clk);
            traffic = traffic | mem_read | mem_write | busywait;
        end
        check_eq("rw_traffic", 64'(traffic), 64'd0);
        @(posedge clk);
        #1;
        read = 1'b0; write = 1'b0;
        check_ops("rw");
        access("rd24h", 1, 0, 8'h24, 8'h00, 8'hAA, 0);

        // reset in the middle of a fetch
        read = 1'b1; address = 8'h84;
        repeat (3) @(negedge clk);
        check_eq("mid_mrd",  64'(mem_read), 64'd1);
        check_eq("mid_addr", 64'(mem_address), 64'h21);
        check_eq("mid_busy", 64'(busywait), 64'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("abort_mrd",  64'(mem_read), 64'd0);
        check_eq("abort_busy", 64'(busywait), 64'd0);
        read = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_eq("abort_nops", 64'(obs_ops.size()), 64'd0);
        obs_ops.delete();
        exp_op(1'b0, 6'h09, 32'hDDCCBBAA);
        access("rd24r", 1, 0, 8'h24, 8'h00, 8'hAA, 5);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/cache_2way_param.md
CACHE_2WAY_PARAM -- requirements
Module: cache_2way_param

Interface
REQ-001 SHALL have parameter ADDR_W, default 8, byte-address width.
REQ-002 SHALL have parameter DATA_W, default 8, CPU word width.
REQ-003 SHALL have parameter IDX_W, default 2, set-index bits (SETS = 2**IDX_W).
REQ-004 SHALL have parameter OFF_W, default 2, word-offset bits (WORDS = 2**OFF_W words per block); TAG_W = ADDR_W-IDX_W-OFF_W.
REQ-005 SHALL have port clock  input  1  single clock; all state updates on rising edge.
REQ-006 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have ports read/write  input  1 each  CPU access requests; address and writedata held stable while busywait high.
REQ-008 SHALL have ports address  input  ADDR_W, writedata  input  DATA_W, readdata  output  DATA_W, busywait  output  1.
REQ-009 SHALL have ports mem_read/mem_write  output  1 each, mem_address  output  ADDR_W-OFF_W  block address.
REQ-010 SHALL have ports mem_writedata  output  DATA_W*WORDS, mem_readdata  input  DATA_W*WORDS, mem_busywait  input  1.

Function
REQ-011 SHALL decode offset=address[OFF_W-1:0], index=next IDX_W bits, tag=top TAG_W bits; word k of a block sits at bits [k*DATA_W +: DATA_W].
REQ-012 SHALL be 2-way set-associative, write-back, write-allocate; per way per set: valid, dirty, tag, block; per set one LRU bit naming the least-recently-used way.
REQ-013 SHALL treat read&&write both high as no access: busywait 0, no state change, no memory traffic.
REQ-014 SHALL compute hit combinationally: IDLE, access pending, and one way valid with tag match.
REQ-015 SHALL drive busywait = access && !(IDLE && hit); a hit completes in the cycle it is presented.
REQ-016 SHALL drive readdata with the addressed word of the hitting way on a read hit, else 0.
REQ-017 SHALL on a write hit update the addressed word, set that way dirty, at the rising edge.
REQ-018 SHALL on any hit set the set's LRU bit to the other way at the rising edge.
REQ-019 SHALL on a miss select victim: way 0 if invalid, else way 1 if invalid, else the LRU way.
REQ-020 SHALL implement states IDLE, WRITEBACK, FETCH: IDLE->WRITEBACK on miss with victim valid and dirty; IDLE->FETCH on miss otherwise.
REQ-021 SHALL in WRITEBACK drive mem_write=1, mem_address={victim tag,index}, mem_writedata=victim block; ->FETCH at first edge with mem_busywait=0.
REQ-022 SHALL in FETCH drive mem_read=1, mem_address={tag,index}; at first edge with mem_busywait=0 load mem_readdata into victim, set tag, valid=1, dirty=0, ->IDLE.
REQ-023 SHALL rely on memory raising mem_busywait in the same cycle mem_read/mem_write rises and holding it until done; minimum one cycle per memory state.
REQ-024 SHALL after FETCH re-evaluate in IDLE so the retried access hits the cycle after the fill (read miss latency = fetch cycles + 1).
REQ-025 SHALL never assert mem_read and mem_write together; both 0 in IDLE.

Reset
REQ-026 SHALL on reset asynchronously force state IDLE, all valid, dirty and LRU bits 0, mem_read=0, mem_write=0, busywait=0; block and tag contents need not clear.
REQ-027 SHALL on reset during WRITEBACK or FETCH abort the transaction immediately with no cache update.

Configuration
REQ-028 SHALL with macro CACHE_STATS_EN defined add outputs hit_count and miss_count (16 bits each), incremented once per completed hit / once per IDLE->miss transition, saturating at 0xFFFF, cleared by reset.
REQ-029 SHALL without CACHE_STATS_EN omit both ports and counters; all other behaviour identical.

Verification (defaults: TAG_W=4, 2 sets-bits, 4 words)
REQ-030 SHALL: after reset, read 0x24 -> FETCH, mem_address=0x09; memory returns 0xDDCCBBAA after 3 cycles -> readdata=0xAA, busywait low next cycle.
REQ-031 SHALL: write 0x25 data 0x5A (resident) -> no mem traffic, busywait 0; then read 0x25 -> readdata=0x5A same cycle.
REQ-032 SHALL: read 0x44 (fills way 1, set 1), read 0x44 again, read 0xC4 -> victim is dirty 0x24 line: mem_write with mem_address=0x09, data=0xDDCC5AAA, then mem_read mem_address=0x31.
REQ-033 SHALL: reset pulsed mid-FETCH -> mem_read drops with reset, busywait 0, subsequent read 0x24 misses again.
REQ-034 SHALL: read=write=1 at 0x24 -> busywait 0, no mem_read/mem_write, no LRU/dirty change.
REQ-035 SHALL (CACHE_STATS_EN): sequence of REQ-030..032 -> hit_count=3, miss_count=3.
